// File: rtl/sprite_motion_ctrl.sv
// Steps one sprite per frame from WASD keycodes, holding turn requests until a tile centre.
// Outputs are registered and change the cycle after frame_tick; walls only matter when tile-aligned.
module sprite_motion_ctrl #(
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 639,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 479,
  parameter int TILE   = 16,
  parameter int STEP   = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       wall_left,
  input  logic       wall_right,
  input  logic       wall_down,
  input  logic       wall_up,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] cur_dir,
  output logic       moving
);

  localparam logic [9:0] STEP_V = 10'(STEP);
  localparam logic [9:0] X_LO   = 10'(X_MIN);
  localparam logic [9:0] X_HI   = 10'(X_MAX + 1 - TILE);
  localparam logic [9:0] Y_LO   = 10'(Y_MIN);
  localparam logic [9:0] Y_HI   = 10'(Y_MAX + 1 - TILE);
  localparam logic [9:0] T_MASK = 10'(TILE - 1);

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_D = 2'b10;
  localparam logic [1:0] DIR_U = 2'b11;

  typedef enum logic {STOPPED, MOVING} state_e;

  state_e     state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0] dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic       pend_vld_q, pend_vld_d;

  logic       key_vld;
  logic [1:0] key_dir;
  logic       req_vld;
  logic [1:0] req_dir, mv_dir;
  logic       aligned, take_rev, take_turn, do_move;
  logic [3:0] walls;

  // The vertical play-field edges behave exactly like walls.
  function automatic logic y_oob(input logic [1:0] d, input logic [9:0] y);
    return ((d == DIR_D) && (y > Y_HI - STEP_V)) || ((d == DIR_U) && (y < Y_LO + STEP_V));
  endfunction

  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_L;
    case (keycode)
      8'h04:   key_dir = DIR_L;
      8'h07:   key_dir = DIR_R;
      8'h16:   key_dir = DIR_D;
      8'h1A:   key_dir = DIR_U;
      default: key_vld = 1'b0;
    endcase
  end

  assign walls     = {wall_up, wall_down, wall_right, wall_left};
  assign req_vld   = key_vld | pend_vld_q;
  assign req_dir   = key_vld ? key_dir : pend_dir_q;
  assign aligned   = ((pos_x_q & T_MASK) == '0) && ((pos_y_q & T_MASK) == '0);
  assign take_rev  = req_vld && (req_dir == (dir_q ^ 2'b01));
  assign take_turn = !take_rev && aligned && req_vld && !walls[req_dir] && !y_oob(req_dir, pos_y_q);
  assign mv_dir    = (take_rev || take_turn) ? req_dir : dir_q;
  assign do_move   = take_rev ? !y_oob(req_dir, pos_y_q)
                   : (take_turn || !(aligned && (walls[dir_q] || y_oob(dir_q, pos_y_q))));

  always_comb begin
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    dir_d      = dir_q;
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    if (frame_tick) begin
      if (take_rev || take_turn) begin
        dir_d      = req_dir;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = req_vld;
        pend_dir_d = req_dir;
      end
      state_d = do_move ? MOVING : STOPPED;
      if (do_move) begin
        case (mv_dir)
          DIR_L:   pos_x_d = (pos_x_q == X_LO) ? X_HI : pos_x_q - STEP_V;
          DIR_R:   pos_x_d = (pos_x_q == X_HI) ? X_LO : pos_x_q + STEP_V;
          DIR_D:   pos_y_d = pos_y_q + STEP_V;
          default: pos_y_d = pos_y_q - STEP_V;
        endcase
      end
    end else if (key_vld) begin
      pend_vld_d = 1'b1;
      pend_dir_d = key_dir;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pos_x_q    <= 10'(X_INIT);
      pos_y_q    <= 10'(Y_INIT);
      dir_q      <= DIR_L;
      state_q    <= STOPPED;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_L;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      dir_q      <= dir_d;
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign cur_dir = dir_q;
  assign moving  = (state_q == MOVING);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboarded bench for sprite_motion_ctrl: directed scenarios then random keycodes/walls/ticks,
// checked every cycle against an integer reference model of the motion rules.
module tb_sprite_motion_ctrl;

  localparam int X_INIT = 320;
  localparam int Y_INIT = 240;
  localparam int X_MIN  = 0;
  localparam int X_MAX  = 639;
  localparam int Y_MIN  = 0;
  localparam int Y_MAX  = 479;
  localparam int TILE   = 16;
  localparam int STEP   = 1;
  localparam int XHI    = X_MAX + 1 - TILE;
  localparam int YHI    = Y_MAX + 1 - TILE;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] d;
    logic       m;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       wall_left, wall_right, wall_down, wall_up;
  logic [9:0] pos_x, pos_y;
  logic [1:0] cur_dir;
  logic       moving;

  sprite_motion_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .wall_left  (wall_left),
    .wall_right (wall_right),
    .wall_down  (wall_down),
    .wall_up    (wall_up),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .cur_dir    (cur_dir),
    .moving     (moving)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t expq[$];
  exp_t mon_e;
  exp_t mon_g;

  // Reference model state: direction 0=left 1=right 2=down 3=up, -1 = no key.
  int mx, my, mdir, mpd;
  bit mmov, mpv;
  int DX [4]  = '{-1, 1, 0, 0};
  int DY [4]  = '{0, 0, 1, -1};
  int REV [4] = '{1, 0, 3, 2};

  function automatic int key2dir(input logic [7:0] k);
    if (k == 8'h04) return 0;
    if (k == 8'h07) return 1;
    if (k == 8'h16) return 2;
    if (k == 8'h1A) return 3;
    return -1;
  endfunction

  function automatic bit m_oob(input int d);
    int ny;
    ny = my + DY[d] * STEP;
    return (ny < Y_MIN) || (ny > YHI);
  endfunction

  function automatic void m_move(input int d);
    int nx;
    nx = mx + DX[d] * STEP;
    if (nx < X_MIN) nx = XHI;
    else if (nx > XHI) nx = X_MIN;
    mx = nx;
    my = my + DY[d] * STEP;
    mmov = 1'b1;
  endfunction

  function automatic void model_reset();
    mx = X_INIT; my = Y_INIT; mdir = 0; mmov = 1'b0; mpv = 1'b0; mpd = 0;
  endfunction

  function automatic void model_step(input bit tick, input logic [7:0] kc, input logic [3:0] w);
    int kd, rd;
    bit rv, al;
    kd = key2dir(kc);
    if (!tick) begin
      if (kd >= 0) begin mpv = 1'b1; mpd = kd; end
      return;
    end
    rv = (kd >= 0) || mpv;
    rd = (kd >= 0) ? kd : mpd;
    al = (mx % TILE == 0) && (my % TILE == 0);
    if (rv && rd == REV[mdir]) begin
      mdir = rd; mpv = 1'b0;
      if (!m_oob(rd)) m_move(rd); else mmov = 1'b0;
    end else if (al && rv && !w[rd] && !m_oob(rd)) begin
      mdir = rd; mpv = 1'b0;
      m_move(rd);
    end else begin
      mpv = rv; mpd = rd;
      if (al && (w[mdir] || m_oob(mdir))) mmov = 1'b0;
      else m_move(mdir);
    end
  endfunction

  task automatic cycle(input bit tick, input logic [7:0] kc, input logic [3:0] w);
    exp_t e;
    @(negedge Clk);
    frame_tick = tick;
    keycode    = kc;
    {wall_up, wall_down, wall_right, wall_left} = w;
    model_step(tick, kc, w);
    e.x = 10'(mx); e.y = 10'(my); e.d = 2'(mdir); e.m = mmov;
    expq.push_back(e);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge arrives.
  task automatic do_reset();
    exp_t g;
    @(posedge Clk);
    #3;
    Reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
    #1;
    g = {pos_x, pos_y, cur_dir, moving};
    vectors++;
    if (g !== {10'(X_INIT), 10'(Y_INIT), 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async got x=%0d y=%0d dir=%0d mv=%0d want x=%0d y=%0d dir=0 mv=0",
               g.x, g.y, g.d, g.m, X_INIT, Y_INIT);
    end
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        mon_g = {pos_x, pos_y, cur_dir, moving};
        vectors++;
        if (mon_g !== mon_e) begin
          miscompares++;
          $display("FAIL out_vec%0d got x=%0d y=%0d dir=%0d mv=%0d want x=%0d y=%0d dir=%0d mv=%0d",
                   vectors, mon_g.x, mon_g.y, mon_g.d, mon_g.m, mon_e.x, mon_e.y, mon_e.d, mon_e.m);
        end
      end
    end
  end

  initial begin
    logic [7:0] kc;
    logic [3:0] w;
    bit         tk;
    Reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
    {wall_up, wall_down, wall_right, wall_left} = 4'b0000;
    model_reset();
    do_reset();

    // Up request one cycle ahead of the tick.
    cycle(0, 8'h1A, 4'b0000); cycle(1, 8'h00, 4'b0000); cycle(0, 8'h00, 4'b0000);
    do_reset();

    // Free run left, then a down request held until x reaches the 304 tile centre.
    cycle(1, 8'h00, 4'b0000); cycle(0, 8'h00, 4'b0000); cycle(1, 8'h00, 4'b0000);
    cycle(0, 8'h16, 4'b0000);
    repeat (15) cycle(1, 8'h00, 4'b0000);
    cycle(0, 8'h00, 4'b0000);
    do_reset();

    // Blocked by a left wall at a tile centre, then an immediate reverse.
    repeat (16) cycle(1, 8'h00, 4'b0000);
    cycle(1, 8'h00, 4'b0001); cycle(1, 8'h00, 4'b0001);
    cycle(0, 8'h07, 4'b0001); cycle(1, 8'h00, 4'b0001);
    cycle(0, 8'h00, 4'b0000);
    do_reset();

    // Tunnel wrap both ways, ignored keycode, same-cycle bypass.
    repeat (321) cycle(1, 8'h00, 4'b0000);
    cycle(1, 8'h2C, 4'b0000);
    cycle(0, 8'h16, 4'b0000);
    cycle(1, 8'h04, 4'b0000);
    repeat (16) cycle(1, 8'h00, 4'b0000);
    cycle(1, 8'h07, 4'b0000);
    repeat (20) cycle(1, 8'h00, 4'b0000);

    // Reset with a request pending: the request must be lost.
    cycle(0, 8'h1A, 4'b0000);
    do_reset();
    cycle(1, 8'h00, 4'b0000); cycle(1, 8'h00, 4'b0000);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: kc = 8'h04;
        1: kc = 8'h07;
        2: kc = 8'h16;
        3: kc = 8'h1A;
        4: kc = 8'($urandom);
        default: kc = 8'h00;
      endcase
      for (int b = 0; b < 4; b++) w[b] = ($urandom_range(0, 3) == 0);
      cycle(tk, kc, w);
      if (i % 997 == 996) do_reset();
    end

    cycle(0, 8'h00, 4'b0000);
    repeat (3) @(posedge Clk);
    #2;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d unchecked want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
